mem_port2_arbiter: RTL and testbench
====================================

# mem_port2_arbiter

Sequential arbiter that shares memory port 2 of the stack CPU's datapath between the control-unit requester (MemRead2/MemWrite2 traffic for stack and PC accesses) and an external requester (program loader / debug DMA). It sequences each access through issue and response cycles and stalls the control FSM while its access is pending. Fixed CPU priority is bounded by a fairness counter so the external requester cannot starve. It sits between the control unit and the memory block; port 1 is not touched.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- FAIR_LIMIT, 4, consecutive CPU grants allowed while ExtReq waits (≥1)
- CLK  in  1  clock, all state on rising edge
- CtrlRst_n  in  1  synchronous, active-low reset
- CpuRead, CpuWrite  in  1 each  CPU request, held until CpuDone
- CpuAddr  in  ADDR_W  CPU address
- CpuWData  in  DATA_W  CPU write data
- CpuRData  out  DATA_W  CPU read data
- CpuDone  out  1  CPU access complete
- CpuStall  out  1  control FSM must hold its state
- ExtReq, ExtWe  in  1 each  external request and write select, held until ExtDone
- ExtAddr  in  ADDR_W  external address
- ExtWData  in  DATA_W  external write data
- ExtGnt  out  1  external request latched
- ExtRData  out  DATA_W  external read data
- ExtDone  out  1  external access complete
- MemAddr  out  ADDR_W  address to memory port 2
- MemWData  out  DATA_W  write data to memory port 2
- MemRead, MemWrite  out  1 each  port 2 strobes
- MemRData  in  DATA_W  port 2 read data, valid one cycle after MemRead

## Operation
- States: IDLE, ISSUE, RESP. Registers: owner (CPU/EXT), latched addr/wdata/we, fair count (0..FAIR_LIMIT), CpuRData and ExtRData holding registers.
- IDLE: arbitrate; if any request, latch winner's addr/wdata/we and owner, go to ISSUE. Else stay.
- Arbitration: CPU wins unless ExtReq=1 and fair count == FAIR_LIMIT; then EXT wins.
- CpuRead and CpuWrite both high: treated as write.
- Fair count: +1 (saturating) on each CPU grant while ExtReq=1; cleared on EXT grant or whenever ExtReq=0 in IDLE.
- ISSUE: MemAddr/MemWData from latched regs; MemWrite=we, MemRead=!we, for exactly one cycle. Go to RESP.
- RESP: owner's Done=1. For a read, owner's RData shows MemRData this cycle and the holding register loads it at the edge. For a write, RData holds. Go to IDLE.
- ExtGnt=1 in the IDLE cycle an EXT grant is latched.
- CpuStall = (CpuRead|CpuWrite) & !CpuDone.
- Requesters sample RData at the end of the Done cycle. They may drop or change the request at that edge. IDLE then sees fresh requests, with no masking.

## Timing
- Reset (CtrlRst_n=0 at edge): state IDLE, fair count 0, RData registers 0. Mem* outputs, Done, and ExtGnt are 0 from the next cycle. Any in-flight access is abandoned, with no Done.
- Latency: request visible in IDLE cycle T, then MemRead/MemWrite at T+1, then Done at T+2.
- Throughput: one access per 3 cycles; the next grant is at the earliest T+3.
- Mem* strobes and Done are derived from state/owner only; no combinational path from requests to Mem*.
- Requests changing in ISSUE/RESP are ignored; latched values are used.

## Structure
- Shared package mem_arb_pkg: state enum (IDLE/ISSUE/RESP), owner encoding (OWN_CPU=0, OWN_EXT=1), ADDR_W/DATA_W defaults.
- One sub-module: arb_fair_counter (saturating counter with inc/clear, terminal flag at FAIR_LIMIT).

## Test plan
- Reset: hold CtrlRst_n=0 two cycles during an active EXT read. Next cycle all outputs are 0, no ExtDone, and state is IDLE.
- CPU read: mem[0x0010]=0xBEEF, CpuRead at T. Then MemRead=1 with MemAddr=0x0010 at T+1, CpuDone=1 and CpuRData=0xBEEF at T+2, and CpuStall is 1 at T..T+1 and 0 at T+2.
- EXT write then read: ExtWe=1, ExtAddr=0x0200, ExtWData=0x1234. ExtGnt at T, MemWrite at T+1, ExtDone at T+2. A read of 0x0200 then returns ExtRData=0x1234.
- Simultaneous CPU read and EXT request at T with count 0: CPU is granted at T. EXT is granted at T+3 once CPU drops its request, and ExtRData is unchanged by the CPU access.
- Fairness: FAIR_LIMIT=2, CPU re-requests every IDLE and ExtReq is held. Grant order is CPU, CPU, EXT, CPU, CPU, EXT.
- CpuRead and CpuWrite both 1 with addr 0x0004 and data 0x00FF: MemWrite=1 and MemRead=0 at T+1, and mem[0x0004]=0x00FF afterward.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port 2 arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_ARB_ADDR_W = 16;
  localparam int unsigned MEM_ARB_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/arb_fair_counter.sv
// Saturating count of CPU grants made while the external requester waits;
// term_o flags that the next grant must go to the external side.
module arb_fair_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic term_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign term_o = (cnt_q == CW'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !term_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port2_arbiter.sv
// Shares memory port 2 between the control unit and an external requester:
// arbitrate in IDLE, strobe memory in ISSUE, report completion in RESP.
module mem_port2_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = MEM_ARB_ADDR_W,
  parameter int unsigned DATA_W     = MEM_ARB_DATA_W,
  parameter int unsigned FAIR_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              CtrlRst_n,
  input  logic              CpuRead,
  input  logic              CpuWrite,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWData,
  output logic [DATA_W-1:0] CpuRData,
  output logic              CpuDone,
  output logic              CpuStall,
  input  logic              ExtReq,
  input  logic              ExtWe,
  input  logic [ADDR_W-1:0] ExtAddr,
  input  logic [DATA_W-1:0] ExtWData,
  output logic              ExtGnt,
  output logic [DATA_W-1:0] ExtRData,
  output logic              ExtDone,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemRData
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

  logic cpu_req;
  logic ext_win;
  logic fair_term;
  logic fair_inc;
  logic fair_clr;

  assign cpu_req = CpuRead | CpuWrite;
  // CPU keeps priority until the fairness budget is spent while EXT waits.
  assign ext_win = ExtReq & (fair_term | ~cpu_req);

  arb_fair_counter #(
    .LIMIT (FAIR_LIMIT)
  ) u_fair (
    .clk_i  (CLK),
    .rst_ni (CtrlRst_n),
    .inc_i  (fair_inc),
    .clr_i  (fair_clr),
    .term_o (fair_term)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    fair_inc    = 1'b0;
    fair_clr    = 1'b0;
    ExtGnt      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!ExtReq) begin
          fair_clr = 1'b1;
        end
        if (ext_win) begin
          owner_d  = OWN_EXT;
          addr_d   = ExtAddr;
          wdata_d  = ExtWData;
          we_d     = ExtWe;
          fair_clr = 1'b1;
          ExtGnt   = 1'b1;
          state_d  = ISSUE;
        end else if (cpu_req) begin
          owner_d  = OWN_CPU;
          addr_d   = CpuAddr;
          wdata_d  = CpuWData;
          // Read and write together resolve to a write.
          we_d     = CpuWrite;
          fair_inc = ExtReq;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        if (!we_q) begin
          if (owner_q == OWN_CPU) begin
            cpu_rdata_d = MemRData;
          end else begin
            ext_rdata_d = MemRData;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    MemAddr  = '0;
    MemWData = '0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    CpuDone  = 1'b0;
    ExtDone  = 1'b0;
    CpuRData = cpu_rdata_q;
    ExtRData = ext_rdata_q;

    unique case (state_q)
      ISSUE: begin
        MemAddr  = addr_q;
        MemWData = wdata_q;
        MemWrite = we_q;
        MemRead  = ~we_q;
      end
      RESP: begin
        if (owner_q == OWN_CPU) begin
          CpuDone = 1'b1;
          if (!we_q) begin
            CpuRData = MemRData;
          end
        end else begin
          ExtDone = 1'b1;
          if (!we_q) begin
            ExtRData = MemRData;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign CpuStall = cpu_req & ~CpuDone;

  always_ff @(posedge CLK) begin
    if (!CtrlRst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port2_arbiter.sv
// Directed bench for mem_port2_arbiter with a behavioural port-2 memory and
// a completion scoreboard (owner + returned data per Done).
module tb_mem_port2_arbiter;

  logic        CLK;
  logic        CtrlRst_n;
  logic        CpuRead, CpuWrite, ExtReq, ExtWe;
  logic [15:0] CpuAddr, CpuWData, ExtAddr, ExtWData;
  logic [15:0] CpuRData, ExtRData, MemAddr, MemWData, MemRData;
  logic        CpuDone, CpuStall, ExtGnt, ExtDone, MemRead, MemWrite;

  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [15:0] pre_data;
  logic [15:0] mem [0:1023];

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        ext;
    logic [15:0] data;
  } sb_ent_t;

  sb_ent_t exp_q[$];
  sb_ent_t done_q[$];

  logic exp_order [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  mem_port2_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .FAIR_LIMIT (2)
  ) dut (
    .CLK       (CLK),
    .CtrlRst_n (CtrlRst_n),
    .CpuRead   (CpuRead),
    .CpuWrite  (CpuWrite),
    .CpuAddr   (CpuAddr),
    .CpuWData  (CpuWData),
    .CpuRData  (CpuRData),
    .CpuDone   (CpuDone),
    .CpuStall  (CpuStall),
    .ExtReq    (ExtReq),
    .ExtWe     (ExtWe),
    .ExtAddr   (ExtAddr),
    .ExtWData  (ExtWData),
    .ExtGnt    (ExtGnt),
    .ExtRData  (ExtRData),
    .ExtDone   (ExtDone),
    .MemAddr   (MemAddr),
    .MemWData  (MemWData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemRData  (MemRData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Port-2 memory: read data registered, valid the cycle after MemRead.
  always @(posedge CLK) begin
    if (MemWrite) mem[MemAddr[9:0]] <= MemWData;
    else if (pre_we) mem[pre_addr] <= pre_data;
    MemRData <= MemRead ? mem[MemAddr[9:0]] : 16'hDEAD;
  end

  always @(posedge CLK) begin
    if (CpuDone) done_q.push_back({1'b0, CpuRData});
    if (ExtDone) done_q.push_back({1'b1, ExtRData});
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic ext, input logic [15:0] data);
    exp_q.push_back({ext, data});
  endtask

  task automatic sb_drain(input string tag);
    sb_ent_t e, o;
    chk({tag, "_count"}, 32'(done_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && done_q.size() > 0) begin
      e = exp_q.pop_front();
      o = done_q.pop_front();
      chk({tag, "_owner"}, 32'(o.ext), 32'(e.ext));
      chk({tag, "_rdata"}, 32'(o.data), 32'(e.data));
    end
    exp_q.delete();
    done_q.delete();
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_strobes"}, 32'({MemRead, MemWrite, CpuDone, ExtDone, ExtGnt, CpuStall}), 0);
    chk({tag, "_maddr"}, 32'(MemAddr), 0);
    chk({tag, "_mwdata"}, 32'(MemWData), 0);
  endtask

  initial begin
    CtrlRst_n = 1'b0;
    CpuRead = 1'b0; CpuWrite = 1'b0; CpuAddr = '0; CpuWData = '0;
    ExtReq = 1'b0; ExtWe = 1'b0; ExtAddr = '0; ExtWData = '0;
    pre_we = 1'b1; pre_addr = 10'h010; pre_data = 16'hBEEF;
    step();
    pre_we = 1'b0;
    step();
    CtrlRst_n = 1'b1;

    // Reset state
    smp();
    chk_idle_outs("rst0");
    chk("rst0_cpurdata", 32'(CpuRData), 0);
    chk("rst0_extrdata", 32'(ExtRData), 0);

    // CPU read of 0x0010
    step();
    CpuRead = 1'b1; CpuAddr = 16'h0010;
    push_exp(1'b0, 16'hBEEF);
    smp();
    chk("cpurd_T_stall", 32'(CpuStall), 1);
    chk("cpurd_T_strobe", 32'({MemRead, MemWrite}), 0);
    step(); smp();
    chk("cpurd_T1_strobe", 32'({MemRead, MemWrite}), 'b10);
    chk("cpurd_T1_addr", 32'(MemAddr), 'h0010);
    chk("cpurd_T1_stall", 32'(CpuStall), 1);
    step(); smp();
    chk("cpurd_T2_done", 32'(CpuDone), 1);
    chk("cpurd_T2_rdata", 32'(CpuRData), 'hBEEF);
    chk("cpurd_T2_stall", 32'(CpuStall), 0);
    step();
    CpuRead = 1'b0;
    smp();
    chk("cpurd_hold", 32'(CpuRData), 'hBEEF);
    sb_drain("sb_cpurd");

    // EXT write 0x1234 to 0x0200, then read it back
    step();
    ExtReq = 1'b1; ExtWe = 1'b1; ExtAddr = 16'h0200; ExtWData = 16'h1234;
    push_exp(1'b1, 16'h0000);
    smp();
    chk("extwr_T_gnt", 32'(ExtGnt), 1);
    step(); smp();
    chk("extwr_T1_strobe", 32'({MemRead, MemWrite}), 'b01);
    chk("extwr_T1_addr", 32'(MemAddr), 'h0200);
    chk("extwr_T1_wdata", 32'(MemWData), 'h1234);
    step(); smp();
    chk("extwr_T2_done", 32'({ExtDone, ExtGnt, CpuDone}), 'b100);
    step();
    ExtWe = 1'b0; ExtWData = 16'h0000;
    push_exp(1'b1, 16'h1234);
    smp();
    chk("extrd_T_gnt", 32'(ExtGnt), 1);
    step(); smp();
    chk("extrd_T1_strobe", 32'({MemRead, MemWrite}), 'b10);
    step(); smp();
    chk("extrd_T2_rdata", 32'(ExtRData), 'h1234);
    step();
    ExtReq = 1'b0;
    smp();
    chk("extrd_hold", 32'(ExtRData), 'h1234);
    sb_drain("sb_ext");

    // Simultaneous CPU read and EXT read with fair count 0
    step();
    CpuRead = 1'b1; CpuAddr = 16'h0010;
    ExtReq = 1'b1; ExtWe = 1'b0; ExtAddr = 16'h0200;
    push_exp(1'b0, 16'hBEEF);
    push_exp(1'b1, 16'h1234);
    smp();
    chk("sim_T_extgnt", 32'(ExtGnt), 0);
    step(); smp();
    chk("sim_T1_addr", 32'(MemAddr), 'h0010);
    step(); smp();
    chk("sim_T2_cpudone", 32'({CpuDone, ExtDone}), 'b10);
    chk("sim_T2_extrdata", 32'(ExtRData), 'h1234);
    step();
    CpuRead = 1'b0;
    smp();
    chk("sim_T3_extgnt", 32'(ExtGnt), 1);
    step(); smp();
    chk("sim_T4_addr", 32'(MemAddr), 'h0200);
    step(); smp();
    chk("sim_T5_extdone", 32'(ExtDone), 1);
    step();
    ExtReq = 1'b0;
    sb_drain("sb_sim");

    // Fairness with FAIR_LIMIT=2: CPU, CPU, EXT, CPU, CPU, EXT
    step();
    CpuRead = 1'b1; CpuAddr = 16'h0010;
    ExtReq = 1'b1; ExtWe = 1'b0; ExtAddr = 16'h0200;
    for (int g = 0; g < 6; g++) begin
      push_exp(exp_order[g], exp_order[g] ? 16'h1234 : 16'hBEEF);
      smp();
      chk($sformatf("fair_gnt%0d", g), 32'(ExtGnt), 32'(exp_order[g]));
      step(); smp();
      chk($sformatf("fair_addr%0d", g), 32'(MemAddr), exp_order[g] ? 'h0200 : 'h0010);
      step(); smp();
      step();
    end
    CpuRead = 1'b0; ExtReq = 1'b0;
    sb_drain("sb_fair");

    // CpuRead and CpuWrite together act as a write
    step();
    CpuRead = 1'b1; CpuWrite = 1'b1; CpuAddr = 16'h0004; CpuWData = 16'h00FF;
    push_exp(1'b0, 16'hBEEF);
    smp();
    chk("both_T_stall", 32'(CpuStall), 1);
    step(); smp();
    chk("both_T1_strobe", 32'({MemRead, MemWrite}), 'b01);
    chk("both_T1_addr", 32'(MemAddr), 'h0004);
    chk("both_T1_wdata", 32'(MemWData), 'h00FF);
    step(); smp();
    chk("both_T2_done", 32'(CpuDone), 1);
    step();
    CpuRead = 1'b0; CpuWrite = 1'b0; CpuWData = '0;
    smp();
    chk("both_mem", 32'(mem[10'h004]), 'h00FF);
    sb_drain("sb_both");

    // Reset held two cycles while an EXT read is in flight
    step();
    ExtReq = 1'b1; ExtWe = 1'b0; ExtAddr = 16'h0200;
    smp();
    chk("rstx_T_gnt", 32'(ExtGnt), 1);
    step();
    CtrlRst_n = 1'b0; ExtReq = 1'b0;
    smp();
    chk("rstx_issue", 32'(MemRead), 1);
    step(); smp();
    chk_idle_outs("rstx_r1");
    chk("rstx_r1_cpurdata", 32'(CpuRData), 0);
    chk("rstx_r1_extrdata", 32'(ExtRData), 0);
    step();
    CtrlRst_n = 1'b1;
    smp();
    chk_idle_outs("rstx_r2");
    step(); smp();
    chk_idle_outs("rstx_r3");
    chk("rstx_extrdata", 32'(ExtRData), 0);
    sb_drain("sb_rst");

    // Fresh CPU read after reset proves the arbiter restarted in IDLE
    step();
    CpuRead = 1'b1; CpuAddr = 16'h0010;
    push_exp(1'b0, 16'hBEEF);
    smp();
    step(); smp();
    chk("post_T1_strobe", 32'({MemRead, MemWrite}), 'b10);
    step(); smp();
    chk("post_T2_rdata", 32'(CpuRData), 'hBEEF);
    step();
    CpuRead = 1'b0;
    sb_drain("sb_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
